misj_toggle_monitor: RTL and testbench



---
 rtl/misj_toggle_monitor.sv | 193 +++++++++++++++++++
 tb/tb_misj_toggle_monitor.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/misj_toggle_monitor.sv
// misj_toggle_monitor
//
// Observes the 14-bit v35 response vector of the misj PLA benchmark. On
// qualified cycles it counts the 0<->1 transitions of each bit over a
// programmable window. It also accumulates a saturating total of all
// transitions. Results are read back through a registered port.
//
// Ports:
//   clk, rst_n  - clock (rising edge) and asynchronous active-low reset
//   start       - pulse: begin a window (accepted in IDLE and DONE only)
//   win_len     - number of transitions to observe, latched on start
//   in_valid    - in_data carries a sample this cycle
//   in_data     - observed v35 vector
//   busy / done - window in progress (ARM, RUN) / window complete (DONE)
//   rd_req      - readout request for counter rd_idx
//   rd_valid    - rd_data is valid (one cycle after rd_req)
//   rd_data     - toggle count of the requested bit, 0 for rd_idx >= WIDTH
//   total       - saturating sum of all toggles in the window
//   sat         - sticky flag: some counter or total clipped this window
module misj_toggle_monitor #(
    parameter int WIDTH = 14,
    parameter int CNT_W = 16,
    parameter int WIN_W = 16,
    parameter int IDX_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIN_W-1:0]   win_len,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    output logic               busy,
    output logic               done,
    input  logic               rd_req,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic               rd_valid,
    output logic [CNT_W-1:0]   rd_data,
    output logic [CNT_W+3:0]   total,
    output logic               sat
);

    localparam int TOT_W = CNT_W + 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     prev;
    logic [WIN_W-1:0]     rem;
    logic [CNT_W-1:0]     cnt      [WIDTH];
    logic [CNT_W-1:0]     cnt_next [WIDTH];
    logic [WIDTH-1:0]     toggles;
    logic                 cnt_clip;
    logic [TOT_W-1:0]     total_next;
    logic                 tot_clip;
    logic [CNT_W-1:0]     rd_sel;

    // Returns {clipped, value}: increment that sticks at the counter maximum.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX)
            return {1'b1, v};
        else
            return {1'b0, v + CNT_W'(1)};
    endfunction

    // Returns {clipped, value}: addition that sticks at the total maximum.
    function automatic logic [TOT_W:0] sat_add(input logic [TOT_W-1:0] a,
                                               input logic [TOT_W-1:0] b);
        logic [TOT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[TOT_W])
            return {1'b1, {TOT_W{1'b1}}};
        else
            return s;
    endfunction

    function automatic logic [TOT_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [TOT_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++)
            c = c + TOT_W'(v[i]);
        return c;
    endfunction

    // Next counter values for a RUN sample; only committed on in_valid.
    always_comb begin
        logic [CNT_W:0] inc;
        logic [TOT_W:0] tsum;
        inc      = '0;
        toggles  = in_data ^ prev;
        cnt_clip = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = cnt[i];
            if (toggles[i]) begin
                inc         = sat_inc(cnt[i]);
                cnt_next[i] = inc[CNT_W-1:0];
                cnt_clip    = cnt_clip | inc[CNT_W];
            end
        end
        tsum       = sat_add(total, popcount(toggles));
        total_next = tsum[TOT_W-1:0];
        tot_clip   = tsum[TOT_W];
    end

    // Readout mux; out-of-range indices read as zero.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < WIDTH; i++)
            if (rd_idx == IDX_W'(i))
                rd_sel = cnt[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            prev  <= '0;
            rem   <= '0;
            total <= '0;
            sat   <= 1'b0;
            for (int i = 0; i < WIDTH; i++)
                cnt[i] <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        for (int i = 0; i < WIDTH; i++)
                            cnt[i] <= '0;
                        total <= '0;
                        sat   <= 1'b0;
                        rem   <= win_len;
                        if (win_len == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ARM;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                end
                ARM: begin
                    // First valid sample is only the baseline.
                    if (in_valid) begin
                        prev  <= in_data;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        prev  <= in_data;
                        total <= total_next;
                        sat   <= sat | cnt_clip | tot_clip;
                        rem   <= rem - WIN_W'(1);
                        for (int i = 0; i < WIDTH; i++)
                            cnt[i] <= cnt_next[i];
                        if (rem == WIN_W'(1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Readout samples the counters before this edge's update, so a read
    // coinciding with a sample returns the pre-update count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req)
                rd_data <= rd_sel;
        end
    end

endmodule

// File: tb/tb_misj_toggle_monitor.sv
module tb_misj_toggle_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] win_len;
    logic        in_valid;
    logic [13:0] in_data;
    logic        rd_req;
    logic [3:0]  rd_idx;

    logic        busy, done, rd_valid, sat;
    logic [15:0] rd_data;
    logic [19:0] total;

    logic        busy4, done4, rd_valid4, sat4;
    logic [3:0]  rd_data4;
    logic [7:0]  total4;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] exp_q  [$];
    logic [3:0]  exp4_q [$];

    always #5 clk = ~clk;

    misj_toggle_monitor dut (
        .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
        .in_valid(in_valid), .in_data(in_data), .busy(busy), .done(done),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid),
        .rd_data(rd_data), .total(total), .sat(sat)
    );

    // Narrow-counter build for saturation; shares all stimulus with dut.
    misj_toggle_monitor #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
        .in_valid(in_valid), .in_data(in_data), .busy(busy4), .done(done4),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid4),
        .rd_data(rd_data4), .total(total4), .sat(sat4)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a readout result appears.
    always @(negedge clk) begin
        if (rd_valid) begin
            if (exp_q.size() == 0) check("rd_unexpected", 1, 0);
            else check("rd_data", rd_data, exp_q.pop_front());
        end
        if (rd_valid4) begin
            if (exp4_q.size() == 0) check("rd4_unexpected", 1, 0);
            else check("rd_data4", rd_data4, exp4_q.pop_front());
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_win(input logic [15:0] len);
        start   = 1'b1;
        win_len = len;
        tick();
        start   = 1'b0;
    endtask

    task automatic sample(input logic [13:0] d, input logic v);
        in_data  = d;
        in_valid = v;
        tick();
        in_valid = 1'b0;
    endtask

    // Back-to-back reads of idx 0..15; expected counts for bit 0, bit 1,
    // bits 2..13, and 0 for the two out-of-range indices.
    task automatic read_all(input logic [15:0] v0, input logic [15:0] v1,
                            input logic [15:0] vr, input logic [3:0] w0,
                            input logic [3:0] w1, input logic [3:0] wr);
        for (int i = 0; i < 16; i++) begin
            rd_req = 1'b1;
            rd_idx = 4'(i);
            exp_q.push_back(i == 0 ? v0 : i == 1 ? v1 : i < 14 ? vr : 16'd0);
            exp4_q.push_back(i == 0 ? w0 : i == 1 ? w1 : i < 14 ? wr : 4'd0);
            tick();
        end
        rd_req = 1'b0;
        tick();
        tick();
        check("rd_drain", exp_q.size() + exp4_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; win_len = '0; in_valid = 1'b0;
        in_data = '0; rd_req = 1'b0; rd_idx = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_total", total, 0);
        check("rst_sat", sat, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);

        // Basic window: baseline 0, then 0->1, 1->3, 3->2.
        start_win(16'd3);
        check("basic_busy", busy, 1);
        sample(14'h0000, 1'b1);
        sample(14'h0001, 1'b1);
        sample(14'h0003, 1'b1);
        check("basic_done_early", done, 0);
        sample(14'h0002, 1'b1);
        check("basic_done", done, 1);
        check("basic_busy_low", busy, 0);
        check("basic_total", total, 3);
        check("basic_total4", total4, 3);
        read_all(16'd2, 16'd1, 16'd0, 4'd2, 4'd1, 4'd0);

        // Zero window.
        start_win(16'd0);
        check("zero_done", done, 1);
        check("zero_total", total, 0);
        for (int i = 0; i < 3; i++) begin
            check("zero_busy", busy, 0);
            tick();
        end

        // Gapped samples plus a start pulse in RUN that must be ignored.
        start_win(16'd3);
        sample(14'h0000, 1'b1);
        sample(14'h3FFF, 1'b0);
        sample(14'h0001, 1'b1);
        sample(14'h3FFF, 1'b0);
        start_win(16'd0);
        check("ignore_start_busy", busy, 1);
        check("ignore_start_total", total, 1);
        sample(14'h0003, 1'b1);
        sample(14'h3FFF, 1'b0);
        sample(14'h0002, 1'b1);
        check("gap_done", done, 1);
        check("gap_total", total, 3);
        sample(14'h3FFF, 1'b1);
        check("done_ignores_valid", total, 3);
        read_all(16'd2, 16'd1, 16'd0, 4'd2, 4'd1, 4'd0);

        // Restart from DONE clears and returns to ARM.
        start_win(16'd2);
        check("restart_busy", busy, 1);
        check("restart_done", done, 0);
        check("restart_total", total, 0);
        read_all(16'd0, 16'd0, 16'd0, 4'd0, 4'd0, 4'd0);
        sample(14'h0005, 1'b1);
        sample(14'h0004, 1'b1);
        check("restart_mid_busy", busy, 1);
        sample(14'h0004, 1'b1);
        check("unchanged_consumes", done, 1);
        check("restart_total_end", total, 1);
        read_all(16'd1, 16'd0, 16'd0, 4'd1, 4'd0, 4'd0);

        // Reset in the middle of RUN with nonzero counts.
        start_win(16'd10);
        sample(14'h0000, 1'b1);
        sample(14'h000F, 1'b1);
        sample(14'h0000, 1'b1);
        check("pre_reset_total", total, 8);
        rd_req = 1'b1; rd_idx = 4'd0;
        exp_q.push_back(16'd2); exp4_q.push_back(4'd2);
        tick();
        rd_req = 1'b0;
        tick();
        rst_n = 1'b0;
        #2;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_total", total, 0);
        check("mid_rst_sat", sat, 0);
        check("mid_rst_rd_data", rd_data, 0);
        check("mid_rst_total4", total4, 0);
        tick();
        rst_n = 1'b1;
        tick();
        start_win(16'd1);
        sample(14'h0000, 1'b1);
        sample(14'h0001, 1'b1);
        check("post_rst_done", done, 1);
        check("post_rst_total", total, 1);
        read_all(16'd1, 16'd0, 16'd0, 4'd1, 4'd0, 4'd0);

        // Saturation: 20 full-vector toggles. Wide build counts 20 per bit
        // (280 total); the 4-bit build clips counters at 15 and its 8-bit
        // total at 255.
        start_win(16'd20);
        sample(14'h0000, 1'b1);
        for (int i = 1; i <= 20; i++)
            sample((i % 2) ? 14'h3FFF : 14'h0000, 1'b1);
        check("sat_done", done, 1);
        check("sat_total", total, 280);
        check("sat_flag_wide", sat, 0);
        check("sat_total4", total4, 255);
        check("sat_flag4", sat4, 1);
        read_all(16'd20, 16'd20, 16'd20, 4'd15, 4'd15, 4'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
